vga_timing_compositor: RTL and testbench
========================================

Name: vga_timing_compositor

Overview:
- Parametrised successor of the fixed 640x480 sync plus RGB mux path in the VGA top.
- Generates a pixel-clock enable, H/V timing, pixel coordinates and a frame pulse.
- Composites N_LAYERS overlay sources (clock, date, timer, ring, boxes) by fixed priority into one RGB output, with per-layer frame-rate blink.
- Sync and RGB outputs are register-aligned; it sits between the layer generators and the VGA pins.

Parameters:
- DIV, 4: clk cycles per pixel; >=1; 4 gives 25 MHz from 100 MHz.
- H_DISP, 640: active pixels per line.
- H_FP, 16: horizontal front porch.
- H_SYNC, 96: horizontal sync pulse width.
- H_BP, 48: horizontal back porch.
- V_DISP, 480: active lines.
- V_FP, 10: vertical front porch.
- V_SYNC, 2: vertical sync pulse width.
- V_BP, 33: vertical back porch.
- CW, 10: coordinate width; H_TOTAL and V_TOTAL must each be <= 2^CW.
- N_LAYERS, 4: overlay channel count; >=1.
- RGB_W, 12: colour width.
- BLINK_FRAMES, 30: frames per blink half-period; >=1.

Ports:
- clk, in, 1: system clock.
- reset, in, 1: asynchronous, active-low reset.
- layer_rgb, in, N_LAYERS*RGB_W: layer i colour in bits [i*RGB_W +: RGB_W].
- layer_valid, in, N_LAYERS: layer i owns the current pixel.
- layer_blink, in, N_LAYERS: layer i is blanked during the blink-off phase.
- bg_rgb, in, RGB_W: background colour.
- p_tick, out, 1: pixel enable, one clk wide.
- pixel_x, out, CW: current horizontal count.
- pixel_y, out, CW: current vertical count.
- video_on, out, 1: current (x,y) lies in the active area.
- frame_start, out, 1: one-clk pulse when counters wrap to (0,0).
- blink_phase, out, 1: 1 = blink-off phase.
- h_sync, out, 1: active-low horizontal sync, aligned with rgb.
- v_sync, out, 1: active-low vertical sync, aligned with rgb.
- rgb, out, RGB_W: composited colour.

Behaviour:
- H_TOTAL = H_DISP+H_FP+H_SYNC+H_BP; V_TOTAL = V_DISP+V_FP+V_SYNC+V_BP.
- Reset values:
  - Divider, counters, frame counter, blink_phase: 0.
  - p_tick, frame_start, rgb: 0.
  - video_on = 1, since (0,0) is active.
  - h_sync and v_sync: 1 (inactive).
- Divider:
  - Counts 0..DIV-1; p_tick=1 in the clk cycle where the divider is DIV-1.
  - DIV=1 gives p_tick constantly high after reset.
- Counters (advance only on p_tick):
  - pixel_x increments and wraps from H_TOTAL-1 to 0.
  - On the x wrap, pixel_y increments and wraps from V_TOTAL-1 to 0.
  - pixel_x and pixel_y are registered and hold between ticks.
  - Blanking values are output unclamped.
- video_on = (pixel_x < H_DISP) && (pixel_y < V_DISP); combinational from the registered counters.
- Sync windows:
  - Horizontal sync is asserted (low) for x in [H_DISP+H_FP, H_DISP+H_FP+H_SYNC-1].
  - Vertical sync is asserted for y in [V_DISP+V_FP, V_DISP+V_FP+V_SYNC-1].
- Layer timing: layers must present data for the current (x,y) before the next p_tick, i.e. within DIV clk cycles of a coordinate change.
- Compositor, one pipeline stage registered on p_tick:
  - Candidate = layer with the lowest index among those with layer_valid[i]=1 and !(layer_blink[i] && blink_phase).
  - If there is no candidate, bg_rgb.
  - rgb <= video_on ? candidate : 0.
  - h_sync and v_sync are registered in the same stage.
  - Result: rgb, h_sync and v_sync lag pixel_x, pixel_y and video_on by exactly one pixel period.
- Blink:
  - frame_start fires on the p_tick where (x,y) goes (H_TOTAL-1, V_TOTAL-1) -> (0,0).
  - The frame counter counts frame_start pulses 0..BLINK_FRAMES-1.
  - On the wrap, blink_phase toggles in the same clk as frame_start.
- Inputs are ignored except on p_tick cycles, so mid-pixel glitches on layer inputs have no effect.
- Reset mid-frame: all state returns to reset values immediately (asynchronous). The first p_tick after release occurs DIV cycles later and advances x to 1.

Optional Feature:
- Macro: VGA_TEST_PATTERN_EN.
- When defined:
  - Adds input test_mode (1 bit).
  - When test_mode=1, the compositor ignores all layers and bg_rgb.
  - Active pixels show 8 vertical bars; bar index = (pixel_x*8)/H_DISP, computed with constant-divisor logic.
  - Colours in order: white, yellow, cyan, green, magenta, red, blue, black, each channel full-scale (RGB_W/3 bits all 1 or 0).
  - Pipeline alignment is unchanged.
- When undefined: the test_mode port and bar logic are absent.

Test Plan:
- Reset held 10 cycles, then released with DIV=4 -> p_tick every 4th clk; one line = 3200 clk; one frame = 420000 p_ticks; frame_start pulses exactly once per frame.
- Sync windows -> h_sync low for pixel_x 656..751 (96 ticks), delayed one tick; v_sync low for lines 490..491; pixel_y wraps 524 -> 0.
- Priority: at (100,100), layer_valid=4'b0110, layer1=12'hF00, layer2=12'h0F0 -> rgb=12'hF00 one pixel period later; layer_valid=0, bg_rgb=12'h00F -> rgb=12'h00F; any blanking pixel -> rgb=0.
- Blink: BLINK_FRAMES=2, layer_blink=4'b0001, layer_valid=4'b0001, layer0=12'hFFF -> rgb alternates FFF for 2 frames, then bg_rgb for 2 frames; blink_phase toggles on every 2nd frame_start.
- Reset asserted asynchronously at pixel (300,200) mid-pixel -> outputs return to reset values within the same clk, without waiting for a clk edge; after release, counting restarts from (0,0).
- VGA_TEST_PATTERN_EN defined, test_mode=1 -> pixel_x 0..79 gives FFF, 80..159 gives FF0, ..., 560..639 gives 000; layers ignored.

Source files
------------

// File: rtl/vga_timing_compositor.sv
// vga_timing_compositor
// Pixel-clock divider, parametrised H/V timing, frame/blink bookkeeping and a
// fixed-priority overlay compositor. rgb, h_sync and v_sync are registered on
// p_tick, so they trail pixel_x/pixel_y/video_on by exactly one pixel period.
// Optional feature: define VGA_TEST_PATTERN_EN to add the test_mode input,
// which replaces the composited image with eight full-scale colour bars.
module vga_timing_compositor #(
    parameter int DIV          = 4,
    parameter int H_DISP       = 640,
    parameter int H_FP         = 16,
    parameter int H_SYNC       = 96,
    parameter int H_BP         = 48,
    parameter int V_DISP       = 480,
    parameter int V_FP         = 10,
    parameter int V_SYNC       = 2,
    parameter int V_BP         = 33,
    parameter int CW           = 10,
    parameter int N_LAYERS     = 4,
    parameter int RGB_W        = 12,
    parameter int BLINK_FRAMES = 30
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_LAYERS*RGB_W-1:0] layer_rgb,
    input  logic [N_LAYERS-1:0]       layer_valid,
    input  logic [N_LAYERS-1:0]       layer_blink,
    input  logic [RGB_W-1:0]          bg_rgb,
`ifdef VGA_TEST_PATTERN_EN
    input  logic                      test_mode,
`endif
    output logic                      p_tick,
    output logic [CW-1:0]             pixel_x,
    output logic [CW-1:0]             pixel_y,
    output logic                      video_on,
    output logic                      frame_start,
    output logic                      blink_phase,
    output logic                      h_sync,
    output logic                      v_sync,
    output logic [RGB_W-1:0]          rgb
);

    localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int FC_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [FC_W-1:0]  FC_LAST  = FC_W'(BLINK_FRAMES - 1);
    localparam logic [CW-1:0]    X_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0]    Y_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0]    X_DISP   = CW'(H_DISP);
    localparam logic [CW-1:0]    Y_DISP   = CW'(V_DISP);
    localparam logic [CW-1:0]    HS_FIRST = CW'(H_DISP + H_FP);
    localparam logic [CW-1:0]    HS_LAST  = CW'(H_DISP + H_FP + H_SYNC - 1);
    localparam logic [CW-1:0]    VS_FIRST = CW'(V_DISP + V_FP);
    localparam logic [CW-1:0]    VS_LAST  = CW'(V_DISP + V_FP + V_SYNC - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic             p_tick_q, p_tick_d;
    logic [CW-1:0]    pixel_x_q, pixel_x_d;
    logic [CW-1:0]    pixel_y_q, pixel_y_d;
    logic [FC_W-1:0]  frame_cnt_q, frame_cnt_d;
    logic             frame_start_q, frame_start_d;
    logic             blink_q, blink_d;
    logic             h_sync_q, h_sync_d;
    logic             v_sync_q, v_sync_d;
    logic [RGB_W-1:0] rgb_q, rgb_d;

    logic             x_last;
    logic             y_last;
    logic             active;
    logic [RGB_W-1:0] cand_rgb;
    logic [RGB_W-1:0] pix_rgb;

    assign x_last = (pixel_x_q == X_LAST);
    assign y_last = (pixel_y_q == Y_LAST);
    assign active = (pixel_x_q < X_DISP) && (pixel_y_q < Y_DISP);

    // Pixel divider; p_tick is registered so it stays low through reset even when DIV=1
    always_comb begin
        div_d    = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
        p_tick_d = (div_d == DIV_LAST);
    end

    // Raster counters, frame pulse and blink phase, all advancing on p_tick only
    always_comb begin
        pixel_x_d     = pixel_x_q;
        pixel_y_d     = pixel_y_q;
        frame_cnt_d   = frame_cnt_q;
        blink_d       = blink_q;
        frame_start_d = 1'b0;
        if (p_tick_q) begin
            if (x_last) begin
                pixel_x_d = '0;
                pixel_y_d = y_last ? '0 : pixel_y_q + 1'b1;
            end else begin
                pixel_x_d = pixel_x_q + 1'b1;
            end
            if (x_last && y_last) begin
                frame_start_d = 1'b1;
                if (frame_cnt_q == FC_LAST) begin
                    frame_cnt_d = '0;
                    blink_d     = ~blink_q;
                end else begin
                    frame_cnt_d = frame_cnt_q + 1'b1;
                end
            end
        end
    end

    // Lowest-index visible layer wins; background when nothing claims the pixel
    always_comb begin
        logic found;
        found    = 1'b0;
        cand_rgb = bg_rgb;
        for (int unsigned i = 0; i < N_LAYERS; i++) begin
            if (!found && layer_valid[i] && !(layer_blink[i] && blink_q)) begin
                cand_rgb = layer_rgb[i*RGB_W +: RGB_W];
                found    = 1'b1;
            end
        end
    end

`ifdef VGA_TEST_PATTERN_EN
    localparam int XS_W = CW + 3;
    localparam int CH_W = RGB_W / 3;

    logic [2:0]       bar_idx;
    logic [RGB_W-1:0] bar_rgb;

    // Eight equal colour bars; bar bits map directly onto the R/G/B on-pattern
    always_comb begin
        bar_idx = 3'({pixel_x_q, 3'b000} / XS_W'(H_DISP));
        bar_rgb = '0;
        bar_rgb[3*CH_W-1:0] = {{CH_W{~bar_idx[1]}}, {CH_W{~bar_idx[2]}}, {CH_W{~bar_idx[0]}}};
        pix_rgb = test_mode ? bar_rgb : cand_rgb;
    end
`else
    // Without the test pattern the compositor output feeds the pipeline directly
    always_comb begin
        pix_rgb = cand_rgb;
    end
`endif

    // Output stage: colour and syncs captured together on p_tick
    always_comb begin
        rgb_d    = rgb_q;
        h_sync_d = h_sync_q;
        v_sync_d = v_sync_q;
        if (p_tick_q) begin
            rgb_d    = active ? pix_rgb : '0;
            h_sync_d = !((pixel_x_q >= HS_FIRST) && (pixel_x_q <= HS_LAST));
            v_sync_d = !((pixel_y_q >= VS_FIRST) && (pixel_y_q <= VS_LAST));
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q         <= '0;
            p_tick_q      <= 1'b0;
            pixel_x_q     <= '0;
            pixel_y_q     <= '0;
            frame_cnt_q   <= '0;
            frame_start_q <= 1'b0;
            blink_q       <= 1'b0;
            h_sync_q      <= 1'b1;
            v_sync_q      <= 1'b1;
            rgb_q         <= '0;
        end else begin
            div_q         <= div_d;
            p_tick_q      <= p_tick_d;
            pixel_x_q     <= pixel_x_d;
            pixel_y_q     <= pixel_y_d;
            frame_cnt_q   <= frame_cnt_d;
            frame_start_q <= frame_start_d;
            blink_q       <= blink_d;
            h_sync_q      <= h_sync_d;
            v_sync_q      <= v_sync_d;
            rgb_q         <= rgb_d;
        end
    end

    assign p_tick      = p_tick_q;
    assign pixel_x     = pixel_x_q;
    assign pixel_y     = pixel_y_q;
    assign video_on    = active;
    assign frame_start = frame_start_q;
    assign blink_phase = blink_q;
    assign h_sync      = h_sync_q;
    assign v_sync      = v_sync_q;
    assign rgb         = rgb_q;

endmodule

// File: tb/tb_vga_timing_compositor.sv
// Bench for vga_timing_compositor using a shrunken raster (24x13 total,
// 16x8 active) so several frames fit in a short run.
module tb_vga_timing_compositor;

    localparam int DIV    = 4;
    localparam int H_DISP = 16;
    localparam int H_FP   = 2;
    localparam int H_SYNC = 3;
    localparam int H_BP   = 3;
    localparam int V_DISP = 8;
    localparam int V_FP   = 1;
    localparam int V_SYNC = 2;
    localparam int V_BP   = 2;
    localparam int CW     = 5;
    localparam int NL     = 4;
    localparam int RW     = 12;
    localparam int BF     = 2;
    localparam int HT     = H_DISP + H_FP + H_SYNC + H_BP;
    localparam int VT     = V_DISP + V_FP + V_SYNC + V_BP;
    localparam int FRAME  = HT * VT;

    localparam logic [27:0] RESET_VAL = {1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 12'h000};

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [NL*RW-1:0]  layer_rgb = '0;
    logic [NL-1:0]     layer_valid = '0;
    logic [NL-1:0]     layer_blink = '0;
    logic [RW-1:0]     bg_rgb = '0;
    logic              tm_drv = 1'b0;

    logic              p_tick, video_on, frame_start, blink_phase, h_sync, v_sync;
    logic [CW-1:0]     pixel_x, pixel_y;
    logic [RW-1:0]     rgb;

    logic              d1_p_tick, d1_video_on, d1_frame_start, d1_blink_phase, d1_h_sync, d1_v_sync;
    logic [CW-1:0]     d1_pixel_x, d1_pixel_y;
    logic [RW-1:0]     d1_rgb;

    logic [27:0]       obs;

    vga_timing_compositor #(
        .DIV(DIV), .H_DISP(H_DISP), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_DISP(V_DISP), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .CW(CW), .N_LAYERS(NL), .RGB_W(RW), .BLINK_FRAMES(BF)
    ) u_dut (
        .clk(clk), .reset(reset), .layer_rgb(layer_rgb), .layer_valid(layer_valid),
        .layer_blink(layer_blink), .bg_rgb(bg_rgb),
`ifdef VGA_TEST_PATTERN_EN
        .test_mode(tm_drv),
`endif
        .p_tick(p_tick), .pixel_x(pixel_x), .pixel_y(pixel_y), .video_on(video_on),
        .frame_start(frame_start), .blink_phase(blink_phase), .h_sync(h_sync),
        .v_sync(v_sync), .rgb(rgb)
    );

    vga_timing_compositor #(
        .DIV(1), .H_DISP(H_DISP), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_DISP(V_DISP), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .CW(CW), .N_LAYERS(NL), .RGB_W(RW), .BLINK_FRAMES(BF)
    ) u_div1 (
        .clk(clk), .reset(reset), .layer_rgb(layer_rgb), .layer_valid(layer_valid),
        .layer_blink(layer_blink), .bg_rgb(bg_rgb),
`ifdef VGA_TEST_PATTERN_EN
        .test_mode(tm_drv),
`endif
        .p_tick(d1_p_tick), .pixel_x(d1_pixel_x), .pixel_y(d1_pixel_y), .video_on(d1_video_on),
        .frame_start(d1_frame_start), .blink_phase(d1_blink_phase), .h_sync(d1_h_sync),
        .v_sync(d1_v_sync), .rgb(d1_rgb)
    );

    assign obs = {p_tick, pixel_x, pixel_y, video_on, frame_start, blink_phase, h_sync, v_sync, rgb};

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n;
    logic [RW-1:0] exp_rgb;
    logic        exp_hs, exp_vs;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at t=%0t: got %0h, expected %0h", name, $time, act, req);
        end
    endtask

    // Reference: colour of raster tick t (pixel t of the free-running raster)
    function automatic logic [RW-1:0] ref_pixel(input int t, input logic [NL-1:0] lv,
                                                input logic [NL-1:0] lb, input logic [NL*RW-1:0] lr,
                                                input logic [RW-1:0] bg, input logic tm);
        int x;
        int y;
        int blink;
        logic [RW-1:0] bars [8];
        bars  = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000};
        x     = t % HT;
        y     = (t / HT) % VT;
        blink = ((t / FRAME) / BF) % 2;
        if (x >= H_DISP || y >= V_DISP) return '0;
        if (tm) return bars[(x * 8) / H_DISP];
        for (int i = 0; i < NL; i++)
            if (lv[i] && !(lb[i] && blink == 1)) return lr[i*RW +: RW];
        return bg;
    endfunction

    // One clk: compare everything against the model, drive inputs, advance
    task automatic step(input bit rnd);
        int t;
        int ph;
        int x;
        int y;
        logic [27:0] req;
        t  = n / DIV;
        ph = n % DIV;
        x  = t % HT;
        y  = (t / HT) % VT;
        req = {ph == DIV - 1, CW'(x), CW'(y), (x < H_DISP && y < V_DISP),
               (t > 0 && t % FRAME == 0 && ph == 0), 1'(((t / FRAME) / BF) % 2),
               exp_hs, exp_vs, exp_rgb};
        check("cycle", 64'(obs), 64'(req));
        if (rnd) begin
            layer_rgb   = 48'({$urandom(), $urandom()});
            layer_valid = NL'($urandom() & $urandom());
            layer_blink = NL'($urandom());
            bg_rgb      = RW'($urandom());
        end
        if (ph == DIV - 1) begin
            exp_rgb = ref_pixel(t, layer_valid, layer_blink, layer_rgb, bg_rgb, tm_drv);
            exp_hs  = !(x >= H_DISP + H_FP && x < H_DISP + H_FP + H_SYNC);
            exp_vs  = !(y >= V_DISP + V_FP && y < V_DISP + V_FP + V_SYNC);
        end
        @(posedge clk);
        n++;
        @(negedge clk);
    endtask

    task automatic model_restart();
        n       = 0;
        exp_rgb = '0;
        exp_hs  = 1'b1;
        exp_vs  = 1'b1;
    endtask

    typedef struct {
        string         name;
        logic [NL-1:0] lv;
        logic [NL-1:0] lb;
        logic [RW-1:0] bg;
        logic [RW-1:0] exp;
    } vec_t;

    initial begin
        vec_t          vt [7];
        logic [RW-1:0] blink_tab [6];
        logic          bp_tab [6];
        logic [RW-1:0] bar_tab [8];
        int t, ph, target, fs_cnt, hs_cnt, hs_first, vs_lines, vs_first, ymax;

        vt[0] = '{"prio_l1_over_l2", 4'b0110, 4'b0000, 12'h555, 12'hF00};
        vt[1] = '{"bg_only",         4'b0000, 4'b0000, 12'h00F, 12'h00F};
        vt[2] = '{"l3_only",         4'b1000, 4'b0000, 12'h555, 12'hAAA};
        vt[3] = '{"all_valid_l0",    4'b1111, 4'b0000, 12'h555, 12'h123};
        vt[4] = '{"blink_flag_on",   4'b0001, 4'b0001, 12'h555, 12'h123};
        vt[5] = '{"l1_blink_flag",   4'b1010, 4'b0010, 12'h555, 12'hF00};
        vt[6] = '{"l2_only",         4'b0100, 4'b0000, 12'h00F, 12'h0F0};
        blink_tab = '{12'hFFF, 12'hFFF, 12'h00F, 12'h00F, 12'hFFF, 12'hFFF};
        bp_tab    = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        bar_tab   = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000};

        // Reset held 10 clks; state checked while asserted
        repeat (10) @(negedge clk);
        check("reset_state", 64'(obs), 64'(RESET_VAL));
        check("div1_reset_p_tick", 64'(d1_p_tick), 64'(0));
        reset = 1'b1;
        model_restart();

        // DIV=1: p_tick stays high from the first edge after release
        for (int i = 0; i < 4; i++) begin
            check("div1_p_tick", 64'(d1_p_tick), 64'(i > 0));
            if (i == 3) check("div1_x", 64'(d1_pixel_x), 64'(2));
            step(0);
        end

        // Priority table, each vector presented for one active pixel
        layer_rgb = {12'hAAA, 12'h0F0, 12'hF00, 12'h123};
        for (int k = 0; k < 7; k++) begin
            while (n % DIV != DIV - 1) step(0);
            layer_valid = vt[k].lv;
            layer_blink = vt[k].lb;
            bg_rgb      = vt[k].bg;
            step(0);
            check(vt[k].name, 64'(rgb), 64'(vt[k].exp));
        end

        // Blink: layer 0 blinking over a blue background across six frames
        layer_valid = 4'b0001;
        layer_blink = 4'b0001;
        layer_rgb   = {12'h000, 12'h000, 12'h000, 12'hFFF};
        bg_rgb      = 12'h00F;
        while (n < 5 * FRAME * DIV + 8) begin
            t  = n / DIV;
            ph = n % DIV;
            if (ph == 0 && t % FRAME == 1 && t / FRAME >= 1)
                check("blink_frame_rgb", 64'(rgb), 64'(blink_tab[t / FRAME]));
            if (ph == 0 && t % FRAME == 0 && t > 0)
                check("blink_phase", 64'(blink_phase), 64'(bp_tab[t / FRAME]));
            if (ph == 0 && t == FRAME + H_DISP + 1)
                check("blank_rgb", 64'(rgb), 64'(0));
            step(0);
        end

        // Asynchronous reset mid-pixel at (3,2)
        target = 5 * FRAME + 2 * HT + 3;
        while (!(n / DIV == target && n % DIV == 1) && n < 7 * FRAME * DIV) step(1);
        check("reached_3_2", 64'({pixel_x, pixel_y}), 64'({5'd3, 5'd2}));
        #2 reset = 1'b0;
        #1 check("async_reset", 64'(obs), 64'(RESET_VAL));
        check("async_reset_div1", 64'(d1_p_tick), 64'(0));
        repeat (3) @(negedge clk);
        reset = 1'b1;
        model_restart();

        // Random layers for three frames; syncs, wrap and frame pulses tallied
        fs_cnt = 0; hs_cnt = 0; hs_first = -1; vs_lines = 0; vs_first = -1; ymax = 0;
        while (n < 3 * FRAME * DIV + 2) begin
            t  = n / DIV;
            ph = n % DIV;
            if (frame_start) fs_cnt++;
            if (int'(pixel_y) > ymax) ymax = int'(pixel_y);
            if (ph == 0 && t > HT && t <= 2 * HT && !h_sync) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = int'(pixel_x);
            end
            if (ph == 0 && t % HT == 1 && !v_sync) begin
                vs_lines++;
                if (vs_first < 0) vs_first = int'(pixel_y);
            end
            step(1);
        end
        check("frame_start_count", 64'(fs_cnt), 64'(3));
        check("y_max", 64'(ymax), 64'(VT - 1));
        check("h_sync_width", 64'(hs_cnt), 64'(H_SYNC));
        check("h_sync_first_x", 64'(hs_first), 64'(H_DISP + H_FP + 1));
        check("v_sync_lines", 64'(vs_lines), 64'(3 * V_SYNC));
        check("v_sync_first_y", 64'(vs_first), 64'(V_DISP + V_FP));

`ifdef VGA_TEST_PATTERN_EN
        // Colour bars replace the layers while test_mode is high
        tm_drv = 1'b1;
        while (n < 3 * FRAME * DIV + 2 * HT * DIV) begin
            t  = n / DIV;
            ph = n % DIV;
            if (ph == 0 && (t - 1) % HT < H_DISP && ((t - 1) / HT) % VT < V_DISP)
                check("test_bar", 64'(rgb), 64'(bar_tab[(((t - 1) % HT) * 8) / H_DISP]));
            step(1);
        end
        tm_drv = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

endmodule
